// File: rtl/mul_iter.sv
// Iterative shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW, one multiplier bit per cycle.
// Define MUL_EARLY_OUT_EN to finish as soon as the remaining multiplier bits are all zero.
module mul_iter #(
    parameter int DW  = 64,
    parameter int RNW = 6
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           flush,
    input  logic           mul_exeparam_valid,
    output logic           mul_exeparam_ready,
    input  logic           rv64m_mul,
    input  logic           rv64m_mulh,
    input  logic           rv64m_mulhsu,
    input  logic           rv64m_mulhu,
    input  logic           rv64m_mulw,
    input  logic [DW-1:0]  src1,
    input  logic [DW-1:0]  src2,
    input  logic [RNW-1:0] rd_idx,
    output logic           mul_res_valid,
    input  logic           mul_res_ready,
    output logic [DW-1:0]  mul_res,
    output logic [RNW-1:0] mul_res_rd
);

    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    logic [2*DW-1:0]  r_mcand;
    logic [2*DW-1:0]  r_acc;
    logic [DW-1:0]    r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic             r_is_w;
    logic             r_is_lo;
    logic [RNW-1:0]   r_rd;
    logic             r_res_valid;
    logic [DW-1:0]    r_res;
    logic [RNW-1:0]   r_res_rd;

    logic             w_any_op;
    logic             w_accept;
    logic             w_s1;
    logic             w_s2;
    logic [2*DW-1:0]  w_acc_nxt;
    logic [DW-1:0]    w_mplier_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_finish;

    // Magnitude as an unsigned value; the most negative input maps to 2^(DW-1).
    function automatic logic [DW-1:0] f_mag(input logic [DW-1:0] x, input logic sgn);
        return sgn ? -x : x;
    endfunction

    // Apply the product sign, then pick the half (or sign-extended word) the opcode wants.
    function automatic logic [DW-1:0] f_format(input logic [2*DW-1:0] acc, input logic neg,
                                               input logic is_w, input logic is_lo);
        logic [2*DW-1:0] p;
        p = neg ? -acc : acc;
        if (is_w)
            return {{(DW-32){p[31]}}, p[31:0]};
        else if (is_lo)
            return p[DW-1:0];
        else
            return p[2*DW-1:DW];
    endfunction

    assign w_any_op = rv64m_mul | rv64m_mulh | rv64m_mulhsu | rv64m_mulhu | rv64m_mulw;
    assign mul_exeparam_ready = (r_state == IDLE) & ~flush;
    assign w_accept = mul_exeparam_valid & mul_exeparam_ready & w_any_op;

    // Only MUL/MULH/MULHSU treat src1 as signed, only MUL/MULH treat src2 as signed.
    assign w_s1 = src1[DW-1] & (rv64m_mul | rv64m_mulh | rv64m_mulhsu);
    assign w_s2 = src2[DW-1] & (rv64m_mul | rv64m_mulh);

    assign w_acc_nxt    = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mplier_nxt = r_mplier >> 1;
    assign w_cnt_nxt    = r_cnt - CW'(1);

`ifdef MUL_EARLY_OUT_EN
    assign w_finish = (w_cnt_nxt == '0) | (w_mplier_nxt == '0);
`else
    assign w_finish = (w_cnt_nxt == '0);
`endif

    assign mul_res_valid = r_res_valid;
    assign mul_res       = r_res;
    assign mul_res_rd    = r_res_rd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_is_w      <= 1'b0;
            r_is_lo     <= 1'b0;
            r_rd        <= '0;
            r_res_valid <= 1'b0;
            r_res       <= '0;
            r_res_rd    <= '0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= CALC;
                        r_acc   <= '0;
                        r_rd    <= rd_idx;
                        r_is_w  <= rv64m_mulw;
                        r_is_lo <= rv64m_mul;
                        if (rv64m_mulw) begin
                            r_mcand  <= {{(2*DW-32){1'b0}}, src1[31:0]};
                            r_mplier <= {{(DW-32){1'b0}}, src2[31:0]};
                            r_cnt    <= CW'(32);
                            r_neg    <= 1'b0;
                        end else begin
                            r_mcand  <= {{DW{1'b0}}, f_mag(src1, w_s1)};
                            r_mplier <= f_mag(src2, w_s2);
                            r_cnt    <= CW'(DW);
                            r_neg    <= w_s1 ^ w_s2;
                        end
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_nxt;
                    r_cnt    <= w_cnt_nxt;
                    if (w_finish) begin
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                        r_res       <= f_format(w_acc_nxt, r_neg, r_is_w, r_is_lo);
                        r_res_rd    <= r_rd;
                    end
                end
                DONE: begin
                    if (mul_res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed vectors, random operations against a plain-arithmetic model,
// backpressure, back-to-back issue, flush and reset. Honours MUL_EARLY_OUT_EN when defined.
module tb_mul_iter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        mul_exeparam_valid = 1'b0;
    logic        mul_exeparam_ready;
    logic [4:0]  ops = 5'b0;  // {mulw, mulhu, mulhsu, mulh, mul}
    logic [63:0] src1 = 64'b0;
    logic [63:0] src2 = 64'b0;
    logic [5:0]  rd_idx = 6'b0;
    logic        mul_res_valid;
    logic        mul_res_ready = 1'b0;
    logic [63:0] mul_res;
    logic [5:0]  mul_res_rd;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mul_iter #(.DW(64), .RNW(6)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .mul_exeparam_valid(mul_exeparam_valid), .mul_exeparam_ready(mul_exeparam_ready),
        .rv64m_mul(ops[0]), .rv64m_mulh(ops[1]), .rv64m_mulhsu(ops[2]),
        .rv64m_mulhu(ops[3]), .rv64m_mulw(ops[4]),
        .src1(src1), .src2(src2), .rd_idx(rd_idx),
        .mul_res_valid(mul_res_valid), .mul_res_ready(mul_res_ready),
        .mul_res(mul_res), .mul_res_rd(mul_res_rd)
    );

    // op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW
    function automatic logic [63:0] ref_res(input int op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        logic [63:0]  w;
        ea = (op <= 2) ? {{64{a[63]}}, a} : {64'b0, a};
        eb = (op <= 1) ? {{64{b[63]}}, b} : {64'b0, b};
        p  = ea * eb;
        w  = {32'b0, a[31:0]} * {32'b0, b[31:0]};
        case (op)
            0:       return p[63:0];
            4:       return {{32{w[31]}}, w[31:0]};
            default: return p[127:64];
        endcase
    endfunction

    function automatic int ref_lat(input int op, input logic [63:0] b);
`ifdef MUL_EARLY_OUT_EN
        logic [63:0] m;
        int hb;
        if (op == 4) m = {32'b0, b[31:0]};
        else if (op <= 1 && b[63]) m = -b;
        else m = b;
        hb = 0;
        for (int i = 0; i < 64; i++) if (m[i]) hb = i + 1;
        return (hb < 1) ? 1 : hb;
`else
        return (op == 4) ? 32 : 64;
`endif
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return {32'b0, $urandom_range(0, 300)};
            4:       return 64'h1 << $urandom_range(0, 63);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one op and wait for the result; lat stays 0 if the result never appears.
    task automatic do_op(input int op, input logic [63:0] a, input logic [63:0] b, input logic [5:0] rd,
                         output logic [63:0] res, output logic [5:0] rrd, output int lat, output logic rdy_low);
        @(negedge CLK);
        ops = 5'b1 << op;
        src1 = a;
        src2 = b;
        rd_idx = rd;
        mul_exeparam_valid = 1'b1;
        @(posedge CLK);
        #1;
        mul_exeparam_valid = 1'b0;
        ops = 5'b0;
        src1 = {$urandom, $urandom};
        src2 = {$urandom, $urandom};
        rd_idx = 6'($urandom);
        lat = 0;
        rdy_low = 1'b1;
        res = '0;
        rrd = '0;
        for (int n = 1; n <= 200; n++) begin
            if (mul_exeparam_ready) rdy_low = 1'b0;
            @(posedge CLK);
            #1;
            if (mul_res_valid) begin
                lat = n;
                break;
            end
        end
        if (mul_exeparam_ready) rdy_low = 1'b0;
        res = mul_res;
        rrd = mul_res_rd;
    endtask

    task automatic consume();
        @(negedge CLK);
        mul_res_ready = 1'b1;
        @(posedge CLK);
        #1;
        mul_res_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({mul_res_valid, mul_res, mul_res_rd} !== 71'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b res=%h rd=%h, want all 0", mul_res_valid, mul_res, mul_res_rd);
        end
        checks++;
        if (mul_exeparam_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", mul_exeparam_ready);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic run_vec(input string name, input int op, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_res);
        logic [63:0] res;
        logic [5:0]  rrd, rd;
        int lat;
        logic rl;
        rd = 6'($urandom);
        do_op(op, a, b, rd, res, rrd, lat, rl);
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s_res: got %h want %h", name, res, exp_res);
        end
        checks++;
        if (lat != ref_lat(op, b)) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, ref_lat(op, b));
        end
        checks++;
        if (rrd !== rd || rl !== 1'b1) begin
            errors++;
            $display("FAIL %s_rd_ready: got rd=%h ready_low=%b want rd=%h ready_low=1", name, rrd, rl, rd);
        end
        consume();
    endtask

    task automatic test_directed();
        run_vec("mulhu_ones", 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
        run_vec("mul_neg3x7", 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run_vec("mulh_min", 1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
        run_vec("mulhsu_m1x2", 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_vec("mulw_max", 4, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        run_vec("mul_zero", 0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'h0);
    endtask

    task automatic test_early_out();
`ifdef MUL_EARLY_OUT_EN
        localparam int L1 = 1, L0 = 1, L80 = 8;
`else
        localparam int L1 = 64, L0 = 64, L80 = 64;
`endif
        logic [63:0] res, a;
        logic [5:0] rrd;
        int lat;
        logic rl;
        a = {$urandom, $urandom};
        do_op(0, a, 64'd1, 6'd1, res, rrd, lat, rl);
        checks++;
        if (res !== a || lat != L1) begin
            errors++;
            $display("FAIL eo_src2_one: got res=%h lat=%0d want res=%h lat=%0d", res, lat, a, L1);
        end
        consume();
        do_op(0, a, 64'd0, 6'd2, res, rrd, lat, rl);
        checks++;
        if (res !== 64'd0 || lat != L0) begin
            errors++;
            $display("FAIL eo_src2_zero: got res=%h lat=%0d want res=0 lat=%0d", res, lat, L0);
        end
        consume();
        do_op(0, 64'd3, 64'h80, 6'd3, res, rrd, lat, rl);
        checks++;
        if (res !== 64'h180 || lat != L80) begin
            errors++;
            $display("FAIL eo_src2_80: got res=%h lat=%0d want res=180 lat=%0d", res, lat, L80);
        end
        consume();
    endtask

    task automatic test_random();
        logic [63:0] res, a, b;
        logic [5:0] rrd, rd;
        int lat, op;
        logic rl;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 4);
            a = pick_operand();
            b = pick_operand();
            rd = 6'($urandom);
            do_op(op, a, b, rd, res, rrd, lat, rl);
            checks++;
            if (res !== ref_res(op, a, b) || rrd !== rd || lat != ref_lat(op, b)) begin
                errors++;
                $display("FAIL rand_op%0d: op=%0d a=%h b=%h got res=%h rd=%h lat=%0d want res=%h rd=%h lat=%0d",
                         i, op, a, b, res, rrd, lat, ref_res(op, a, b), rd, ref_lat(op, b));
            end
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            consume();
            checks++;
            if (mul_res_valid !== 1'b0 || mul_exeparam_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_consume%0d: got valid=%b ready=%b want 0/1", i, mul_res_valid, mul_exeparam_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res, hold_res, a, b;
        logic [5:0] rrd, hold_rd;
        int lat;
        logic rl, stable;
        do_op(2, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_0000_FFFF_0000, 6'h2A, res, rrd, lat, rl);
        hold_res = res;
        hold_rd = rrd;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK);
            #1;
            if (mul_res_valid !== 1'b1 || mul_res !== hold_res || mul_res_rd !== hold_rd) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1 || hold_res !== ref_res(2, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_0000_FFFF_0000)) begin
            errors++;
            $display("FAIL backpressure_hold: got stable=%b res=%h want stable=1 res=%h", stable, hold_res,
                     ref_res(2, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_0000_FFFF_0000));
        end
        // Release the result while already presenting the next issue.
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        @(negedge CLK);
        mul_res_ready = 1'b1;
        mul_exeparam_valid = 1'b1;
        ops = 5'b00001;
        src1 = a;
        src2 = b;
        rd_idx = 6'h15;
        @(posedge CLK);
        #1;
        mul_res_ready = 1'b0;
        checks++;
        if (mul_res_valid !== 1'b0 || mul_exeparam_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_release: got valid=%b ready=%b want 0/1", mul_res_valid, mul_exeparam_ready);
        end
        @(posedge CLK);
        #1;
        mul_exeparam_valid = 1'b0;
        ops = 5'b0;
        checks++;
        if (mul_exeparam_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got ready=%b want 0", mul_exeparam_ready);
        end
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge CLK);
            #1;
            if (mul_res_valid) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != ref_lat(0, b) || mul_res !== ref_res(0, a, b) || mul_res_rd !== 6'h15) begin
            errors++;
            $display("FAIL b2b_result: got res=%h rd=%h lat=%0d want res=%h rd=15 lat=%0d",
                     mul_res, mul_res_rd, lat, ref_res(0, a, b), ref_lat(0, b));
        end
        consume();
    endtask

    task automatic test_flush();
        logic rose;
        @(negedge CLK);
        ops = 5'b01000;
        src1 = 64'hFFFF_FFFF_FFFF_FFFF;
        src2 = 64'hFFFF_FFFF_FFFF_FFFF;
        mul_exeparam_valid = 1'b1;
        @(posedge CLK);
        #1;
        mul_exeparam_valid = 1'b0;
        ops = 5'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        #1;
        checks++;
        if (mul_exeparam_ready !== 1'b1 || mul_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: got ready=%b valid=%b want 1/0", mul_exeparam_ready, mul_res_valid);
        end
        rose = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(posedge CLK);
            #1;
            if (mul_res_valid) rose = 1'b1;
        end
        checks++;
        if (rose !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_result: got valid_rose=%b want 0", rose);
        end
        // Flush coinciding with an issue must block the accept.
        @(negedge CLK);
        ops = 5'b00001;
        src1 = 64'd5;
        src2 = 64'd5;
        mul_exeparam_valid = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (mul_exeparam_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready_low: got %b want 0", mul_exeparam_ready);
        end
        @(posedge CLK);
        #1;
        mul_exeparam_valid = 1'b0;
        ops = 5'b0;
        flush = 1'b0;
        #1;
        checks++;
        if (mul_exeparam_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_blocks_accept: got ready=%b want 1", mul_exeparam_ready);
        end
    endtask

    task automatic test_rst_mid();
        @(negedge CLK);
        ops = 5'b00010;
        src1 = 64'h8000_0000_0000_0000;
        src2 = 64'h7FFF_FFFF_FFFF_FFFF;
        rd_idx = 6'h3F;
        mul_exeparam_valid = 1'b1;
        @(posedge CLK);
        #1;
        mul_exeparam_valid = 1'b0;
        ops = 5'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        checks++;
        if ({mul_res_valid, mul_res, mul_res_rd} !== 71'b0 || mul_exeparam_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_calc: got valid=%b res=%h rd=%h ready=%b want 0/0/0/1",
                     mul_res_valid, mul_res, mul_res_rd, mul_exeparam_ready);
        end
        repeat (70) @(posedge CLK);
        #1;
        checks++;
        if (mul_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_result: got valid=%b want 0", mul_res_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_early_out();
        test_random();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
